// File: rtl/debounce_bank.sv
// N-channel button conditioner: 2-flop sync, integrating debounce, press/release pulses.
// Optional hold-to-repeat pulses are built when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_bank #(
    parameter int N          = 4,
    parameter int CNT_W      = 19,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_PER = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_btn,
    output logic [N-1:0] o_state,
    output logic [N-1:0] o_press,
    output logic [N-1:0] o_release,
    output logic [N-1:0] o_repeat,
    output logic         o_any
);

    logic [N-1:0]     sync_0;
    logic [N-1:0]     sync_1;
    logic [CNT_W-1:0] cnt [N];
    logic [N-1:0]     flip;

    // A channel toggles when it has disagreed for a full counter span.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N; i++) begin
            flip[i] = (sync_1[i] != o_state[i]) && (&cnt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0    <= '0;
            sync_1    <= '0;
            o_state   <= '0;
            o_press   <= '0;
            o_release <= '0;
            // NOTE: the counter array is live state, not storage, so it is reset with everything else.
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_0    <= i_btn;
            sync_1    <= sync_0;
            o_state   <= o_state ^ flip;
            o_press   <= flip & ~o_state;
            o_release <= flip & o_state;
            for (int i = 0; i < N; i++) begin
                if ((sync_1[i] == o_state[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 1);

    logic [RW-1:0] rpt_cnt [N];

    // The counter is 0 in the press cycle; a pulse lands when it would reach
    // REPEAT_DLY, and the reload keeps later pulses REPEAT_PER apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_repeat <= '0;
            for (int i = 0; i < N; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!o_state[i] || flip[i]) begin
                    rpt_cnt[i]  <= '0;
                    o_repeat[i] <= 1'b0;
                end else if (rpt_cnt[i] == RW'(REPEAT_DLY - 1)) begin
                    rpt_cnt[i]  <= RW'(REPEAT_DLY - REPEAT_PER);
                    o_repeat[i] <= 1'b1;
                end else begin
                    rpt_cnt[i]  <= rpt_cnt[i] + RW'(1);
                    o_repeat[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign o_repeat = '0;
`endif

    assign o_any = |o_state;

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a sample-history model.
// Expects repeat pulses only when DEBOUNCE_BANK_REPEAT_EN is defined.
module tb_debounce_bank;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int DLY   = 40;
    localparam int PER   = 10;
    localparam int H     = 2 ** CNT_W;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_btn;
    logic [N-1:0] o_state, o_press, o_release, o_repeat;
    logic         o_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N(N), .CNT_W(CNT_W), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_state(o_state), .o_press(o_press), .o_release(o_release),
        .o_repeat(o_repeat), .o_any(o_any)
    );

    // Reference: a channel flips when the synchronised samples seen over the
    // last 2^CNT_W cycles all differ from its current level.
    logic [N-1:0] m_state, m_press, m_release, m_repeat;
    logic [N-1:0] hist [$];
    int           edge_no;
    int           press_edge [N];

    always @(posedge clk or posedge rst) begin
        bit all_diff;
        int d;
        if (rst) begin
            m_state   = '0;
            m_press   = '0;
            m_release = '0;
            m_repeat  = '0;
            edge_no   = 0;
            hist.delete();
            for (int k = 0; k <= H; k++) hist.push_back('0);
        end else begin
            edge_no++;
            m_press   = '0;
            m_release = '0;
            m_repeat  = '0;
            for (int c = 0; c < N; c++) begin
                all_diff = 1'b1;
                for (int j = 0; j < H; j++) begin
                    if (hist[j][c] == m_state[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    if (m_state[c]) begin
                        m_release[c] = 1'b1;
                    end else begin
                        m_press[c]    = 1'b1;
                        press_edge[c] = edge_no;
                    end
                    m_state[c] = ~m_state[c];
                end else if (m_state[c]) begin
`ifdef DEBOUNCE_BANK_REPEAT_EN
                    d = edge_no - press_edge[c];
                    if (d >= DLY && ((d - DLY) % PER) == 0) m_repeat[c] = 1'b1;
`endif
                end
            end
            hist.push_back(i_btn);
            void'(hist.pop_front());
        end
    end

    function automatic logic [4*N:0] model_vec();
        return {m_state, m_press, m_release, m_repeat, |m_state};
    endfunction

    function automatic logic [4*N:0] dut_vec();
        return {o_state, o_press, o_release, o_repeat, o_any};
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        i_btn = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=0", dut_vec());
        end
        i_btn = '1;
        repeat (25) @(negedge clk);
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_held_inputs got=%h exp=0", dut_vec());
        end
        i_btn = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int lat = -1;
        int npress = 0;
        @(negedge clk);
        i_btn[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL clean_press k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (o_press[0]) begin
                npress++;
                if (lat < 0) lat = k;
            end
        end
        checks++;
        if (lat !== 18 || npress !== 1) begin
            errors++;
            $display("FAIL clean_press_latency got lat=%0d n=%0d exp lat=18 n=1", lat, npress);
        end
    endtask

    task automatic test_bounce();
        int npress = 0;
        int lat = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL bounce t=%0d got=%h exp=%h", t, dut_vec(), model_vec());
            end
            if (o_press[1] || o_release[1]) npress++;
            i_btn[1] = ((t / 5) % 2) == 0;
        end
        checks++;
        if (npress !== 0) begin
            errors++;
            $display("FAIL bounce_quiet got=%0d pulses exp=0", npress);
        end
        i_btn[1] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL bounce_settle k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (o_press[1]) begin
                npress++;
                if (lat < 0) lat = k;
            end
        end
        checks++;
        if (lat !== 18 || npress !== 1) begin
            errors++;
            $display("FAIL bounce_press got lat=%0d n=%0d exp lat=18 n=1", lat, npress);
        end
    endtask

    task automatic test_hold_repeat();
        int found = 0;
        int nrep = 0;
        int first_rep = -1;
        int last_rep = -1;
        int rel_at = -1;
        int late_rep = 0;
        int exp_n;
        @(negedge clk);
        i_btn[2] = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (o_press[2]) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL hold_press_timeout got=none exp=press within 40 cycles");
            return;
        end
        for (int q = 1; q <= 100; q++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL hold q=%0d got=%h exp=%h", q, dut_vec(), model_vec());
            end
            if (o_repeat[2]) begin
                nrep++;
                if (first_rep < 0) first_rep = q;
                last_rep = q;
                if (rel_at >= 0) late_rep++;
            end
            if (o_release[2]) rel_at = q;
            if (q == 45) i_btn[2] = 1'b0;
        end
`ifdef DEBOUNCE_BANK_REPEAT_EN
        exp_n = 3;
`else
        exp_n = 0;
`endif
        checks++;
        if (nrep !== exp_n || late_rep !== 0) begin
            errors++;
            $display("FAIL hold_repeat_count got=%0d late=%0d exp=%0d late=0", nrep, late_rep, exp_n);
        end
        if (exp_n != 0) begin
            checks++;
            if (first_rep !== 40 || last_rep !== 60) begin
                errors++;
                $display("FAIL hold_repeat_times got first=%0d last=%0d exp first=40 last=60",
                         first_rep, last_rep);
            end
        end
        checks++;
        if (rel_at !== 63) begin
            errors++;
            $display("FAIL hold_release_time got=%0d exp=63", rel_at);
        end
    endtask

    task automatic test_simultaneous();
        int nev = 0;
        logic [N-1:0] seen = '0;
        @(negedge clk);
        i_btn = '0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL simul_clear k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        i_btn = 4'b1001;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL simul k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (o_press != '0) begin
                nev++;
                seen = o_press;
            end
        end
        checks++;
        if (nev !== 1 || seen !== 4'b1001 || o_any !== 1'b1) begin
            errors++;
            $display("FAIL simul_press got n=%0d press=%b any=%b exp n=1 press=1001 any=1",
                     nev, seen, o_any);
        end
    endtask

    task automatic test_reset_mid();
        int lat = -1;
        logic [N-1:0] seen = '0;
        @(negedge clk);
        i_btn[1] = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=0", dut_vec());
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_recover k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (o_press != '0 && lat < 0) begin
                lat  = k;
                seen = o_press;
            end
        end
        checks++;
        if (lat !== 18 || seen !== 4'b1011) begin
            errors++;
            $display("FAIL reset_reaccept got lat=%0d press=%b exp lat=18 press=1011", lat, seen);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random t=%0d got=%h exp=%h", t, dut_vec(), model_vec());
            end
            for (int c = 0; c < N; c++) begin
                if ($urandom_range((8 << c) - 1) == 0) i_btn[c] = ~i_btn[c];
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
